// File: rtl/rx_bit_ctrl.sv
// Receive bit-timing controller: synchronizes rx, detects start, pulses sh at mid-bit.
// Optional RX_FALSE_START_EN: reject a start whose mid-bit sample reads high.
module rx_bit_ctrl #(
  parameter int FRAME_BITS = 10,
  parameter int BAUD_W     = 19
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              sh,
  output logic              done,
  output logic              busy,
  output logic [3:0]        bit_idx
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0]        LAST_IDX = 4'(FRAME_BITS);
  localparam logic [BAUD_W-1:0] K_MIN    = BAUD_W'(4);
  localparam logic [BAUD_W-1:0] ONE      = BAUD_W'(1);

  logic              sync1_r;
  logic              rxs_r;
  logic              armed_r;
  state_t            state_r;
  logic [BAUD_W-1:0] timer_r;
  logic [3:0]        bit_idx_r;
  logic              sh_r;
  logic              done_r;
  logic              busy_r;

  state_t            state_nxt_s;
  logic [BAUD_W-1:0] timer_nxt_s;
  logic [3:0]        bit_idx_nxt_s;
  logic              armed_nxt_s;
  logic              sh_nxt_s;
  logic              done_nxt_s;
  logic              busy_nxt_s;
  logic              start_ok_s;

  logic [BAUD_W-1:0] k_s;
  logic [BAUD_W-1:0] half_cmp_s;
  logic [BAUD_W-1:0] full_cmp_s;

  assign k_s        = (baud_k < K_MIN) ? K_MIN : baud_k;
  assign half_cmp_s = (k_s >> 1) - ONE;
  assign full_cmp_s = k_s - ONE;

  // sync1_r is next cycle's rxs, so the registered sh can anticipate a false start.
`ifdef RX_FALSE_START_EN
  assign start_ok_s = ~sync1_r;
`else
  assign start_ok_s = 1'b1;
`endif

  // State register: synchronizer, FSM state, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_r   <= 1'b1;
      rxs_r     <= 1'b1;
      armed_r   <= 1'b0;
      state_r   <= ST_IDLE;
      timer_r   <= {BAUD_W{1'b0}};
      bit_idx_r <= 4'd0;
      sh_r      <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      sync1_r   <= rx;
      rxs_r     <= sync1_r;
      armed_r   <= armed_nxt_s;
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      bit_idx_r <= bit_idx_nxt_s;
      sh_r      <= sh_nxt_s;
      done_r    <= done_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  // Next-state logic: start detection, sample-point timing and bit counting.
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_r;
    bit_idx_nxt_s = bit_idx_r;
    armed_nxt_s   = armed_r;
    case (state_r)
      ST_IDLE: begin
        timer_nxt_s   = {BAUD_W{1'b0}};
        bit_idx_nxt_s = 4'd0;
        if (rxs_r) begin
          armed_nxt_s = 1'b1;
        end else if (armed_r) begin
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (timer_r == half_cmp_s) begin
          timer_nxt_s = {BAUD_W{1'b0}};
`ifdef RX_FALSE_START_EN
          if (rxs_r) begin
            state_nxt_s = ST_IDLE;
            armed_nxt_s = 1'b1;
          end else begin
            state_nxt_s   = ST_DATA;
            bit_idx_nxt_s = 4'd1;
          end
`else
          state_nxt_s   = ST_DATA;
          bit_idx_nxt_s = 4'd1;
`endif
        end else begin
          timer_nxt_s = timer_r + ONE;
        end
      end
      ST_DATA: begin
        if (timer_r == full_cmp_s) begin
          timer_nxt_s   = {BAUD_W{1'b0}};
          bit_idx_nxt_s = bit_idx_r + 4'd1;
          if (bit_idx_r + 4'd1 == LAST_IDX) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          timer_nxt_s = timer_r + ONE;
        end
      end
      ST_DONE: begin
        state_nxt_s   = ST_IDLE;
        armed_nxt_s   = 1'b0;
        bit_idx_nxt_s = 4'd0;
        timer_nxt_s   = {BAUD_W{1'b0}};
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        armed_nxt_s   = 1'b0;
        bit_idx_nxt_s = 4'd0;
        timer_nxt_s   = {BAUD_W{1'b0}};
      end
    endcase
  end

  // Output decode from next state so sh/done/busy are registered yet cycle-exact.
  always_comb begin
    sh_nxt_s   = 1'b0;
    done_nxt_s = 1'b0;
    busy_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_START: begin
        sh_nxt_s   = (timer_nxt_s == half_cmp_s) && start_ok_s;
        busy_nxt_s = 1'b1;
      end
      ST_DATA: begin
        sh_nxt_s   = (timer_nxt_s == full_cmp_s);
        busy_nxt_s = 1'b1;
      end
      ST_DONE: begin
        done_nxt_s = 1'b1;
        busy_nxt_s = 1'b1;
      end
      default: begin
        sh_nxt_s   = 1'b0;
        done_nxt_s = 1'b0;
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  assign sh      = sh_r;
  assign done    = done_r;
  assign busy    = busy_r;
  assign bit_idx = bit_idx_r;

endmodule

// File: tb/tb_rx_bit_ctrl.sv
// Randomized bench for rx_bit_ctrl: per-cycle outputs checked against a frame-offset model.
module tb_rx_bit_ctrl;

  localparam int NMAX = 20000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic [18:0] baud_k;
  logic        sh;
  logic        done;
  logic        busy;
  logic [3:0]  bit_idx;
  logic [9:0]  shreg = 10'd0;

  bit         rx_a   [NMAX];
  bit         rst_a  [NMAX];
  int         bk_a   [NMAX];
  logic [6:0] exp_vec[NMAX];
  bit         exp_ok [NMAX];
  bit         frm_chk[NMAX];
  logic [9:0] frm_exp[NMAX];

  int wp = 0;
  int n_cyc;
  int n_checks = 0;
  int n_pass = 0;
  int sc2_done;

  rx_bit_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .rx     (rx),
    .baud_k (baud_k),
    .sh     (sh),
    .done   (done),
    .busy   (busy),
    .bit_idx(bit_idx)
  );

  always #5 clk = ~clk;

  // Downstream shift register stand-in, LSB-first.
  always @(posedge clk) begin
    if (sh) shreg <= {rx, shreg[9:1]};
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int eff_k(input int k);
    return (k < 4) ? 4 : k;
  endfunction

  function automatic bit rxs_at(input int c);
    if (c < 2) return 1'b1;
    if (rst_a[c-1] || rst_a[c-2]) return 1'b1;
    return rx_a[c-2];
  endfunction

  task automatic put(input bit v, input int n, input int k);
    for (int i = 0; i < n; i++) begin
      rx_a[wp] = v;
      bk_a[wp] = k;
      wp++;
    end
  endtask

  task automatic put_frame(input logic [7:0] d, input bit stop, input int k);
    int ke;
    ke = eff_k(k);
    put(1'b0, ke, k);
    for (int i = 0; i < 8; i++) put(d[i], ke, k);
    put(stop, ke, k);
  endtask

  // Reference model: a frame is described only by its first START cycle c0 and K.
  task automatic build_model();
    bit in_fr = 1'b0, armed = 1'b0, valid = 1'b0, reject = 1'b0;
    int c0 = 0, kf = 4, h = 2, off, last, idx;
    bit e_sh, e_done;
    logic [9:0] mframe = 10'd0;
    for (int c = 0; c < n_cyc; c++) begin
      exp_ok[c]  = valid;
      frm_chk[c] = 1'b0;
      if (!in_fr) begin
        exp_vec[c] = 7'd0;
      end else begin
        off    = c - c0;
        last   = h - 1 + 9 * kf;
        e_sh   = !reject && off >= h - 1 && off <= last && ((off - (h - 1)) % kf == 0);
        e_done = !reject && off == last + 1;
        idx    = (reject || off < h) ? 0 : (off - h) / kf + 1;
        exp_vec[c] = {e_sh, e_done, 1'b1, 4'(idx)};
        if (e_sh) mframe = {rx_a[c], mframe[9:1]};
        if (e_done) begin
          frm_chk[c] = 1'b1;
          frm_exp[c] = mframe;
        end
      end
      if (rst_a[c]) begin
        in_fr = 1'b0;
        armed = 1'b0;
        valid = 1'b1;
      end else if (!in_fr) begin
        if (rxs_at(c)) armed = 1'b1;
        else if (armed) begin
          in_fr  = 1'b1;
          c0     = c + 1;
          kf     = eff_k(bk_a[c + 1]);
          h      = kf >> 1;
          reject = 1'b0;
`ifdef RX_FALSE_START_EN
          reject = rxs_at(c0 + h - 1);
`endif
        end
      end else begin
        off = c - c0;
        if (reject && off == h - 1) begin
          in_fr = 1'b0;
          armed = 1'b1;
        end else if (!reject && off == h + 9 * kf) begin
          in_fr = 1'b0;
          armed = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int f, k, ke;
    for (int i = 0; i < NMAX; i++) begin
      rx_a[i]  = 1'b1;
      rst_a[i] = 1'b0;
      bk_a[i]  = 16;
    end
    // 1: reset then idle-high line
    put(1'b1, 305, 16);
    for (int i = 0; i < 5; i++) rst_a[i] = 1'b1;
    // 2: nominal frame 0xA5
    f = wp;
    put_frame(8'hA5, 1'b1, 16);
    sc2_done = f + 2 + 8 + 9 * 16 + 1;
    put(1'b1, 40, 16);
    // 3: reset right after the 4th sh, line continues the frame
    f = wp;
    put_frame(8'h96, 1'b1, 16);
    rst_a[f + 2 + 8 + 3 * 16 + 1] = 1'b1;
    put(1'b1, 60, 16);
    put_frame(8'h3C, 1'b1, 16);
    put(1'b1, 40, 16);
    // 4: framing error then stuck-low line
    put_frame(8'h5A, 1'b0, 16);
    put(1'b0, 100, 16);
    put(1'b1, 40, 16);
    put_frame(8'hC3, 1'b1, 16);
    put(1'b1, 40, 16);
    // 5: short low glitch
    put(1'b0, 3, 16);
    put(1'b1, 220, 16);
    // 6: baud_k below minimum
    put_frame(8'h71, 1'b1, 2);
    put(1'b1, 20, 2);
    // randomized frames, gaps, glitches
    for (int it = 0; it < 24; it++) begin
      if (wp > NMAX - 1200) break;
      k  = $urandom_range(0, 24);
      ke = eff_k(k);
      put(1'b1, 4, k);
      put_frame(8'($urandom), ($urandom_range(0, 7) != 0), k);
      put(1'b1, $urandom_range(4, 3 * ke), k);
      if ($urandom_range(0, 3) == 0) begin
        put(1'b1, 20, k);
        put(1'b0, $urandom_range(1, 3), k);
        put(1'b1, 11 * ke + 20, k);
      end
    end
    put(1'b1, 10, 16);
    n_cyc = wp;
    build_model();

    for (int c = 0; c < n_cyc; c++) begin
      if (c > 0) @(posedge clk);
      #1;
      rx     = rx_a[c];
      reset  = rst_a[c];
      baud_k = 19'(bk_a[c]);
      if (c > 0) begin
        @(negedge clk);
        if (exp_ok[c]) begin
          check_eq($sformatf("out c%0d", c), int'({sh, done, busy, bit_idx}), int'(exp_vec[c]));
          if (frm_chk[c]) check_eq($sformatf("frame c%0d", c), int'(shreg), int'(frm_exp[c]));
          if (c == sc2_done) check_eq("frame_a5", int'(shreg), int'(10'h34A));
        end
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
